lt24_sysid_checker: RTL and testbench

//   Avalon-MM read master that sequences the system-ID slave: reads word 0 (ID),

---
 rtl/lt24_sysid_checker.sv | 145 ++++++++++++++
 tb/tb_lt24_sysid_checker.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/lt24_sysid_checker.sv
// lt24_sysid_checker: Avalon-MM read master that fetches the system-ID slave's
// ID word (addr 0) and timestamp word (addr 1) and compares both against
// build-time values. Results are sticky until the next check starts.
module lt24_sysid_checker #(
  parameter logic [31:0] EXPECTED_ID        = 32'd0,
  parameter logic [31:0] EXPECTED_TIMESTAMP = 32'd1403179550,
  parameter int          READ_LATENCY       = 0,
  parameter int          TIMEOUT_CYCLES     = 255,
  parameter int          AUTO_START         = 1
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  output logic        avm_address,
  output logic        avm_read,
  input  logic        avm_waitrequest,
  input  logic [31:0] avm_readdata,
  output logic        busy,
  output logic        done,
  output logic        pass,
  output logic [1:0]  mismatch,
  output logic        timeout,
  output logic [31:0] id_value,
  output logic [31:0] ts_value
);

  typedef enum logic [2:0] {S_IDLE, S_RD_ID, S_LAT_ID, S_RD_TS, S_LAT_TS, S_DONE} state_t;

  localparam bit         HAS_LAT  = (READ_LATENCY > 0);
  localparam logic [1:0] LAT_LAST = 2'((READ_LATENCY > 0) ? READ_LATENCY - 1 : 0);
  localparam logic [15:0] TO_LIMIT = 16'(TIMEOUT_CYCLES);

  state_t      r_state, w_next;
  logic [15:0] r_tcnt;
  logic [1:0]  r_lcnt;
  logic        r_rst_seen;
  logic        r_pass, r_timeout;
  logic [1:0]  r_mismatch;
  logic [31:0] r_id, r_ts;

  logic        w_start, w_expire, w_lat_end;
  logic        w_cap_id, w_cap_ts, w_clear, w_to_hit;
  logic [31:0] w_id_nxt, w_ts_nxt;

  // r_rst_seen is high only on the first cycle after reset release
  assign w_start   = start | ((AUTO_START != 0) & r_rst_seen);
  assign w_expire  = (16'(r_tcnt + 16'd1) == TO_LIMIT);
  assign w_lat_end = (r_lcnt == LAT_LAST);

  // Next-state and per-cycle capture/clear decisions
  always_comb begin
    w_next   = r_state;
    w_cap_id = 1'b0;
    w_cap_ts = 1'b0;
    w_clear  = 1'b0;
    w_to_hit = 1'b0;
    case (r_state)
      S_IDLE: if (w_start) begin
        w_next  = S_RD_ID;
        w_clear = 1'b1;
      end
      S_RD_ID: begin
        if (!avm_waitrequest) begin
          w_next   = HAS_LAT ? S_LAT_ID : S_RD_TS;
          w_cap_id = !HAS_LAT;
        end else if (w_expire) begin
          w_next   = S_DONE;
          w_to_hit = 1'b1;
        end
      end
      S_LAT_ID: if (w_lat_end) begin
        w_next   = S_RD_TS;
        w_cap_id = 1'b1;
      end
      S_RD_TS: begin
        if (!avm_waitrequest) begin
          w_next   = HAS_LAT ? S_LAT_TS : S_DONE;
          w_cap_ts = !HAS_LAT;
        end else if (w_expire) begin
          w_next   = S_DONE;
          w_to_hit = 1'b1;
        end
      end
      S_LAT_TS: if (w_lat_end) begin
        w_next   = S_DONE;
        w_cap_ts = 1'b1;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // Captured words as they will be after this edge; results are judged on these
  always_comb begin
    w_id_nxt = w_clear ? 32'd0 : (w_cap_id ? avm_readdata : r_id);
    w_ts_nxt = w_clear ? 32'd0 : (w_cap_ts ? avm_readdata : r_ts);
  end

  // State, counters and sticky result registers
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_tcnt     <= '0;
      r_lcnt     <= '0;
      r_rst_seen <= 1'b1;
      r_pass     <= 1'b0;
      r_mismatch <= '0;
      r_timeout  <= 1'b0;
      r_id       <= '0;
      r_ts       <= '0;
    end else begin
      r_state    <= w_next;
      r_rst_seen <= 1'b0;
      // stall counter restarts from zero every time a read phase begins
      r_tcnt     <= ((r_state == S_RD_ID || r_state == S_RD_TS) && avm_waitrequest)
                    ? 16'(r_tcnt + 16'd1) : 16'd0;
      r_lcnt     <= ((r_state == S_LAT_ID || r_state == S_LAT_TS) && !w_lat_end)
                    ? 2'(r_lcnt + 2'd1) : 2'd0;
      r_id       <= w_id_nxt;
      r_ts       <= w_ts_nxt;
      if (w_clear) begin
        r_pass     <= 1'b0;
        r_mismatch <= '0;
        r_timeout  <= 1'b0;
      end
      if (w_to_hit) r_timeout <= 1'b1;
      // a timed-out check leaves pass/mismatch at their cleared zero values
      if (w_next == S_DONE && r_state != S_DONE && !w_to_hit) begin
        r_pass     <= (w_id_nxt == EXPECTED_ID) && (w_ts_nxt == EXPECTED_TIMESTAMP);
        r_mismatch <= {w_ts_nxt != EXPECTED_TIMESTAMP, w_id_nxt != EXPECTED_ID};
      end
    end
  end

  assign avm_read    = (r_state == S_RD_ID) || (r_state == S_RD_TS);
  assign avm_address = (r_state == S_RD_TS);
  assign busy        = (r_state != S_IDLE);
  assign done        = (r_state == S_DONE);
  assign pass        = r_pass;
  assign mismatch    = r_mismatch;
  assign timeout     = r_timeout;
  assign id_value    = r_id;
  assign ts_value    = r_ts;

endmodule

// File: tb/tb_lt24_sysid_checker.sv
// Bench for lt24_sysid_checker: two instances (zero-latency/auto-start and
// latency-2/timeout-8/manual-start), each fed by a small Avalon slave model.
module tb_lt24_sysid_checker;
  localparam logic [31:0] EID = 32'd0;
  localparam logic [31:0] ETS = 32'd1403179550;

  logic        clock = 1'b0;
  logic        reset;
  logic        start [2];
  logic        rd [2], addr [2], wr [2];
  logic        busy [2], done [2], pass [2], tmo [2];
  logic [1:0]  mm [2];
  logic [31:0] rdata [2], idv [2], tsv [2];

  int checks = 0;
  int fails  = 0;

  always #5 clock = ~clock;

  lt24_sysid_checker dut0 (
    .clock(clock), .reset(reset), .start(start[0]),
    .avm_address(addr[0]), .avm_read(rd[0]), .avm_waitrequest(wr[0]), .avm_readdata(rdata[0]),
    .busy(busy[0]), .done(done[0]), .pass(pass[0]), .mismatch(mm[0]), .timeout(tmo[0]),
    .id_value(idv[0]), .ts_value(tsv[0]));

  lt24_sysid_checker #(.READ_LATENCY(2), .TIMEOUT_CYCLES(8), .AUTO_START(0)) dut1 (
    .clock(clock), .reset(reset), .start(start[1]),
    .avm_address(addr[1]), .avm_read(rd[1]), .avm_waitrequest(wr[1]), .avm_readdata(rdata[1]),
    .busy(busy[1]), .done(done[1]), .pass(pass[1]), .mismatch(mm[1]), .timeout(tmo[1]),
    .id_value(idv[1]), .ts_value(tsv[1]));

  function automatic int lat_of(input int d); return (d != 0) ? 2 : 0; endfunction
  function automatic int to_of(input int d);  return (d != 0) ? 8 : 255; endfunction

  // ---------------- slave model ----------------
  logic [31:0] id_word [2], ts_word [2];
  int          stalls_id [2], stalls_ts [2];
  int          scnt_id [2], scnt_ts [2];
  logic [2:0]  sh [2];
  int          done_cnt [2];

  initial begin
    for (int d = 0; d < 2; d++) begin
      sh[d] = '0; scnt_id[d] = 0; scnt_ts[d] = 0; done_cnt[d] = 0;
      id_word[d] = EID; ts_word[d] = ETS; stalls_id[d] = 0; stalls_ts[d] = 0;
    end
  end

  always @(posedge clock) begin
    for (int d = 0; d < 2; d++) begin
      sh[d] <= {sh[d][1:0], addr[d]};
      if (done[d]) done_cnt[d] <= done_cnt[d] + 1;
      if (!busy[d]) begin
        scnt_id[d] <= 0;
        scnt_ts[d] <= 0;
      end else if (rd[d] && wr[d]) begin
        if (addr[d]) scnt_ts[d] <= scnt_ts[d] + 1;
        else         scnt_id[d] <= scnt_id[d] + 1;
      end
    end
  end

  always_comb begin
    for (int d = 0; d < 2; d++) begin
      logic a;
      wr[d] = rd[d] && (addr[d] ? (scnt_ts[d] < stalls_ts[d]) : (scnt_id[d] < stalls_id[d]));
      a = (lat_of(d) == 0) ? addr[d] : sh[d][lat_of(d) - 1];
      rdata[d] = a ? ts_word[d] : id_word[d];
    end
  end

  // ---------------- checking helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // one clock; also checks address stability under stall and read only while busy
  task automatic tick();
    logic prd [2], pwr [2], pad [2];
    for (int d = 0; d < 2; d++) begin prd[d] = rd[d]; pwr[d] = wr[d]; pad[d] = addr[d]; end
    @(posedge clock); #1;
    for (int d = 0; d < 2; d++) begin
      if (prd[d] && pwr[d] && rd[d]) chk($sformatf("addr_hold%0d", d), 32'(addr[d]), 32'(pad[d]));
      if (rd[d]) chk($sformatf("read_in_busy%0d", d), 32'(busy[d]), 32'd1);
    end
  endtask

  // reference outcome from the behavioural rules: latency, flags and captured words
  task automatic model(input int d, input logic [31:0] idw, tsw, input int sid, sts,
                       output bit ep, output logic [1:0] em, output bit et,
                       output logic [31:0] eidv, etsv, output int elat);
    int t, l;
    t = to_of(d); l = lat_of(d);
    if (sid >= t) begin
      et = 1; ep = 0; em = 2'b00; eidv = 32'd0; etsv = 32'd0; elat = 1 + t;
    end else if (sts >= t) begin
      et = 1; ep = 0; em = 2'b00; eidv = idw; etsv = 32'd0; elat = 1 + (1 + sid) + l + t;
    end else begin
      et = 0; ep = (idw == EID) && (tsw == ETS);
      em = {tsw != ETS, idw != EID}; eidv = idw; etsv = tsw;
      elat = 3 + 2 * l + sid + sts;
    end
  endtask

  task automatic run(input int d, input logic [31:0] idw, tsw, input int sid, sts,
                     input bit ep, input logic [1:0] em, input bit et,
                     input logic [31:0] eidv, etsv, input int elat, input string tag);
    int n;
    id_word[d] = idw; ts_word[d] = tsw; stalls_id[d] = sid; stalls_ts[d] = sts;
    start[d] = 1'b1; tick(); start[d] = 1'b0; n = 1;
    while (!done[d] && n < 400) begin tick(); n++; end
    chk({tag, " latency"}, 32'(n), 32'(elat));
    chk({tag, " busy_at_done"}, 32'(busy[d]), 32'd1);
    chk({tag, " pass"}, 32'(pass[d]), 32'(ep));
    chk({tag, " mismatch"}, 32'(mm[d]), 32'(em));
    chk({tag, " timeout"}, 32'(tmo[d]), 32'(et));
    chk({tag, " id_value"}, idv[d], eidv);
    chk({tag, " ts_value"}, tsv[d], etsv);
    tick();
    chk({tag, " done_pulse"}, 32'(done[d]), 32'd0);
    chk({tag, " busy_fall"}, 32'(busy[d]), 32'd0);
    chk({tag, " pass_sticky"}, 32'(pass[d]), 32'(ep));
  endtask

  typedef struct {
    int d; logic [31:0] idw, tsw; int sid, sts;
    bit ep; logic [1:0] em; bit et; logic [31:0] eidv, etsv; int elat;
  } vec_t;

  vec_t tbl [10];

  initial begin #500000; $display("FAIL watchdog: simulation time limit reached"); $fatal(1); end

  initial begin
    int n, dc;
    bit ep, et; logic [1:0] em; logic [31:0] eidv, etsv; int elat;

    tbl[0] = '{0, EID, ETS, 0, 0, 1'b1, 2'b00, 1'b0, EID, ETS, 3};
    tbl[1] = '{0, EID, 32'h12345678, 0, 0, 1'b0, 2'b10, 1'b0, EID, 32'h12345678, 3};
    tbl[2] = '{0, 32'd5, ETS, 0, 0, 1'b0, 2'b01, 1'b0, 32'd5, ETS, 3};
    tbl[3] = '{0, 32'd7, 32'd9, 2, 1, 1'b0, 2'b11, 1'b0, 32'd7, 32'd9, 6};
    tbl[4] = '{1, EID, ETS, 0, 3, 1'b1, 2'b00, 1'b0, EID, ETS, 10};
    tbl[5] = '{1, EID, ETS, 1000, 0, 1'b0, 2'b00, 1'b1, 32'd0, 32'd0, 9};
    tbl[6] = '{1, EID, ETS, 7, 0, 1'b1, 2'b00, 1'b0, EID, ETS, 14};
    tbl[7] = '{1, 32'hAB, ETS, 0, 8, 1'b0, 2'b00, 1'b1, 32'hAB, 32'd0, 12};
    tbl[8] = '{0, EID, ETS, 254, 0, 1'b1, 2'b00, 1'b0, EID, ETS, 257};
    tbl[9] = '{0, EID, ETS, 0, 255, 1'b0, 2'b00, 1'b1, EID, 32'd0, 257};

    reset = 1'b1; start[0] = 1'b0; start[1] = 1'b0;
    tick(); tick(); tick();
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_busy%0d", d), 32'(busy[d]), 32'd0);
      chk($sformatf("rst_read%0d", d), 32'(rd[d]), 32'd0);
      chk($sformatf("rst_pass%0d", d), 32'(pass[d]), 32'd0);
      chk($sformatf("rst_done%0d", d), 32'(done[d]), 32'd0);
      chk($sformatf("rst_id%0d", d), idv[d], 32'd0);
    end

    // auto start on dut0 only
    reset = 1'b0; n = 0;
    do begin tick(); n++; end while (!done[0] && n < 50);
    chk("auto latency", 32'(n), 32'd3);
    chk("auto pass", 32'(pass[0]), 32'd1);
    tick();
    chk("no_auto dut1 busy", 32'(busy[1]), 32'd0);
    chk("no_auto dut1 done_cnt", 32'(done_cnt[1]), 32'd0);

    for (int i = 0; i < 10; i++)
      run(tbl[i].d, tbl[i].idw, tbl[i].tsw, tbl[i].sid, tbl[i].sts, tbl[i].ep, tbl[i].em,
          tbl[i].et, tbl[i].eidv, tbl[i].etsv, tbl[i].elat, $sformatf("vec%0d", i));

    // reset while dut0 is stalled on the timestamp read
    id_word[0] = EID; ts_word[0] = ETS; stalls_id[0] = 0; stalls_ts[0] = 1000;
    start[0] = 1'b1; tick(); start[0] = 1'b0; tick(); tick();
    chk("pre_rst in RD_TS addr", 32'(addr[0]), 32'd1);
    chk("pre_rst in RD_TS read", 32'(rd[0]), 32'd1);
    reset = 1'b1; tick();
    chk("mid_rst read", 32'(rd[0]), 32'd0);
    chk("mid_rst busy", 32'(busy[0]), 32'd0);
    chk("mid_rst pass", 32'(pass[0]), 32'd0);
    chk("mid_rst timeout", 32'(tmo[0]), 32'd0);
    stalls_ts[0] = 0; dc = done_cnt[1];
    reset = 1'b0; n = 0;
    do begin tick(); n++; end while (!done[0] && n < 50);
    chk("rerun latency", 32'(n), 32'd3);
    chk("rerun pass", 32'(pass[0]), 32'd1);
    tick();

    // start while busy and during DONE is ignored
    dc = done_cnt[1];
    id_word[1] = EID; ts_word[1] = ETS; stalls_id[1] = 2; stalls_ts[1] = 0;
    start[1] = 1'b1; tick(); start[1] = 1'b0; tick();
    start[1] = 1'b1; tick(); start[1] = 1'b0; n = 0;
    while (!done[1] && n < 50) begin tick(); n++; end
    chk("ign done seen", 32'(done[1]), 32'd1);
    start[1] = 1'b1; tick(); start[1] = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("ign one done", 32'(done_cnt[1] - dc), 32'd1);
    chk("ign idle", 32'(busy[1]), 32'd0);

    // randomized checks against the behavioural model
    for (int i = 0; i < 40; i++) begin
      int d, sid, sts;
      logic [31:0] idw, tsw;
      d   = int'($urandom_range(0, 1));
      idw = ($urandom_range(0, 2) == 0) ? 32'($urandom) : EID;
      tsw = ($urandom_range(0, 2) == 0) ? 32'($urandom) : ETS;
      sid = int'($urandom_range(0, (d != 0) ? 10 : 6));
      sts = int'($urandom_range(0, (d != 0) ? 10 : 6));
      model(d, idw, tsw, sid, sts, ep, em, et, eidv, etsv, elat);
      run(d, idw, tsw, sid, sts, ep, em, et, eidv, etsv, elat, $sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
